// File: rtl/switch_pkg.sv
// Types and helpers shared by the switch_4port ingress and egress blocks.
package switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 8;
  localparam int PORT_ID_W = $clog2(NUM_PORTS);

  typedef logic [NUM_PORTS-1:0] port_mask_t;
  typedef logic [PORT_ID_W-1:0] port_id_t;

  // One-hot pick of the first set bit of mask at ptr, ptr+1, ... wrapping.
  function automatic port_mask_t rr_pick(input port_mask_t mask, input port_id_t ptr);
    port_mask_t pick;
    port_id_t   idx;
    pick = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = port_id_t'((int'(ptr) + k) % NUM_PORTS);
      if (mask[idx]) pick = port_mask_t'(1) << idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int N  = NUM_PORTS,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  if (N == NUM_PORTS) begin : g_pkg
    assign grant = rr_pick(req, ptr);
  end else begin : g_generic
    // Scan from the farthest candidate down so the nearest one is kept.
    always_comb begin
      grant = '0;
      for (int k = N - 1; k >= 0; k--) begin
        if (req[(int'(ptr) + k) % N]) begin
          grant = '0;
          grant[(int'(ptr) + k) % N] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

endmodule

// File: rtl/switch_out_port.sv
// Egress arbiter for one switch_4port output: round-robin over input heads,
// registered beat output and per-source saturating delivery counters.
module switch_out_port #(
  parameter int PORT_ID   = 0,
  parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
  parameter int DATA_W    = switch_pkg::DATA_W,
  parameter int CNT_W     = 16,
  parameter int SRC_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*DATA_W-1:0] head_data,
  input  logic                        out_en,
  input  logic                        cnt_clr,
  output logic [NUM_PORTS-1:0]        grant,
  output logic                        valid_out,
  output logic [SRC_W-1:0]            source_out,
  output logic [DATA_W-1:0]           data_out,
  output logic [NUM_PORTS*CNT_W-1:0]  pkt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (PORT_ID < 0 || PORT_ID >= NUM_PORTS) begin : g_bad_port_id
    $error("switch_out_port: PORT_ID out of range");
  end

  logic [NUM_PORTS-1:0] elig;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [SRC_W-1:0]     arb_idx;
  logic                 any_grant;

  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] last_grant_q, last_grant_d;
  logic                 valid_q, valid_d;
  logic [SRC_W-1:0]     source_q, source_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [CNT_W-1:0]     cnt_d [NUM_PORTS];

  // The head served last cycle is still requesting until its input port
  // clears the target bit, so it is masked out to avoid a double grant.
  assign elig = req & ~last_grant_q & {NUM_PORTS{out_en & rst_n}};

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (SRC_W)
  ) u_arb (
    .req       (elig),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign grant     = arb_grant;
  assign any_grant = |arb_grant;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    last_grant_d = arb_grant;
    valid_d      = any_grant;
    source_d     = source_q;
    data_d       = data_q;
    if (any_grant) begin
      rr_ptr_d = (arb_idx == SRC_W'(NUM_PORTS - 1)) ? '0 : arb_idx + 1'b1;
      source_d = arb_idx;
      data_d   = head_data[arb_idx*DATA_W +: DATA_W];
    end
  end

  // Counting follows the registered beat; a clear wins over a same-cycle beat.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (valid_q && source_q == SRC_W'(i) && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      last_grant_q <= '0;
      valid_q      <= 1'b0;
      source_q     <= '0;
      data_q       <= '0;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      last_grant_q <= last_grant_d;
      valid_q      <= valid_d;
      source_q     <= source_d;
      data_q       <= data_d;
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign valid_out  = valid_q;
  assign source_out = source_q;
  assign data_out   = data_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt_out
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_switch_out_port.sv
// Self-checking bench for switch_out_port: directed scenarios plus random
// traffic from emulated input ports, checked against a behavioural model.
module tb_switch_out_port;

  localparam int NP     = 4;
  localparam int DW     = 8;
  localparam int CW     = 16;
  localparam int CW_SAT = 2;
  localparam int MAX16  = 65535;
  localparam int MAX2   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP*DW-1:0] head_data;
  logic             out_en;
  logic             cnt_clr;

  logic [NP-1:0]        grant, grant_s;
  logic                 valid_out, valid_s;
  logic [1:0]           source_out, source_s;
  logic [DW-1:0]        data_out, data_s;
  logic [NP*CW-1:0]     pkt_cnt;
  logic [NP*CW_SAT-1:0] pkt_cnt_s;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: rotating priority start, input served last cycle, current beat.
  int         m_ptr;
  int         m_last;
  bit         m_valid;
  int         m_src;
  logic [7:0] m_data;
  int         m_cnt   [NP];
  int         m_cnt_s [NP];
  int         exp_g;

  always #5 clk = ~clk;

  switch_out_port #(.PORT_ID(0), .NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .head_data(head_data),
    .out_en(out_en), .cnt_clr(cnt_clr), .grant(grant), .valid_out(valid_out),
    .source_out(source_out), .data_out(data_out), .pkt_cnt(pkt_cnt)
  );

  switch_out_port #(.PORT_ID(1), .NUM_PORTS(NP), .DATA_W(DW), .CNT_W(CW_SAT)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .head_data(head_data),
    .out_en(out_en), .cnt_clr(cnt_clr), .grant(grant_s), .valid_out(valid_s),
    .source_out(source_s), .data_out(data_s), .pkt_cnt(pkt_cnt_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int modelPick(input logic [NP-1:0] r, input logic en, input logic rn);
    int i;
    if (!en || !rn) return -1;
    for (int k = 0; k < NP; k++) begin
      i = (m_ptr + k) % NP;
      if (r[i] && i != m_last) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_ptr = 0; m_last = -1; m_valid = 0; m_src = 0; m_data = '0;
    for (int i = 0; i < NP; i++) begin
      m_cnt[i] = 0;
      m_cnt_s[i] = 0;
    end
  endtask

  task automatic checkAll();
    logic [NP-1:0] exp_mask;
    exp_mask = (exp_g < 0) ? '0 : (NP'(1) << exp_g);
    checkOutput("grant", grant, exp_mask);
    checkOutput("grant_sat", grant_s, exp_mask);
    checkOutput("valid_out", valid_out, m_valid);
    checkOutput("valid_sat", valid_s, m_valid);
    checkOutput("source_out", source_out, m_src);
    checkOutput("data_out", data_out, m_data);
    for (int i = 0; i < NP; i++) begin
      checkOutput($sformatf("pkt_cnt[%0d]", i), pkt_cnt[i*CW +: CW], m_cnt[i]);
      checkOutput($sformatf("pkt_cnt_sat[%0d]", i), pkt_cnt_s[i*CW_SAT +: CW_SAT], m_cnt_s[i]);
    end
  endtask

  // Drive one cycle's inputs (at posedge+1) and check the settled outputs.
  task automatic applyStimulus(input logic [NP-1:0] r, input logic en, input logic clr);
    req = r; out_en = en; cnt_clr = clr;
    #1;
    exp_g = modelPick(req, out_en, rst_n);
    checkAll();
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NP; i++) begin
      if (cnt_clr) begin
        m_cnt[i] = 0;
        m_cnt_s[i] = 0;
      end else if (m_valid && m_src == i) begin
        if (m_cnt[i] < MAX16) m_cnt[i]++;
        if (m_cnt_s[i] < MAX2) m_cnt_s[i]++;
      end
    end
    m_valid = (exp_g >= 0);
    if (exp_g >= 0) begin
      m_src  = exp_g;
      m_data = head_data[exp_g*DW +: DW];
      m_ptr  = (exp_g + 1) % NP;
    end
    m_last = exp_g;
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_cnt_zero", {31'b0, |pkt_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [NP-1:0] t3_req [6];
  logic [NP-1:0] t3_gnt [6];
  logic [NP-1:0] pend;
  int            g_prev, g_prev2;

  initial begin
    t3_req = '{4'b1111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    t3_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};

    // 1: reset with every input requesting
    rst_n = 1'b0; req = '1; out_en = 1'b1; cnt_clr = 1'b0;
    head_data = $urandom;
    modelReset();
    #12;
    checkOutput("t1_grant", grant, 0);
    checkOutput("t1_valid", valid_out, 0);
    checkOutput("t1_cnt_zero", {31'b0, |pkt_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 2: single source gets every other cycle
    head_data[2*DW +: DW] = 8'hA5;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b0100, 1'b1, 1'b0);
      checkOutput("t2_grant", grant, (c % 2 == 0) ? 4'b0100 : 4'b0000);
      checkOutput("t2_valid", valid_out, (c % 2 == 1) ? 1 : 0);
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t2_cnt2", pkt_cnt[2*CW +: CW], 3);
    checkOutput("t2_src", source_out, 2);
    checkOutput("t2_data", data_out, 8'hA5);
    tick();

    // 4: pointer at 3 wraps past idle input 3 with no bubble
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("t4_grant_a", grant, 4'b0001);
    tick();
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("t4_grant_b", grant, 4'b0010);
    checkOutput("t4_src_a", source_out, 0);
    tick();
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("t4_valid_b", valid_out, 1);
    checkOutput("t4_src_b", source_out, 1);
    tick();

    // reset while a beat is on the output discards it
    applyStimulus(4'b0001, 1'b1, 1'b0);
    tick();
    checkOutput("midrst_valid_pre", valid_out, 1);
    doReset();

    // 3: full round robin with requests dropping after service
    for (int c = 0; c < 6; c++) begin
      applyStimulus(t3_req[c], 1'b1, 1'b0);
      checkOutput("t3_grant", grant, t3_gnt[c]);
      tick();
    end

    // 5: disable right after a grant; the registered beat still drains
    applyStimulus(4'b0001, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkOutput("t5_grant", grant, 0);
      checkOutput("t5_valid", valid_out, (c == 0) ? 1 : 0);
      tick();
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("t5_resume", grant, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    tick();

    // 6: saturation of the narrow counter, then clear beats a beat
    doReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(4'b0010, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    checkOutput("t6_sat", pkt_cnt_s[1*CW_SAT +: CW_SAT], 3);
    checkOutput("t6_wide", pkt_cnt[1*CW +: CW], 5);
    tick();
    applyStimulus(4'b0010, 1'b1, 1'b1);
    checkOutput("t6_beat", valid_out, 1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0);
    checkOutput("t6_clr_sat", pkt_cnt_s[1*CW_SAT +: CW_SAT], 0);
    checkOutput("t6_clr_wide", pkt_cnt[1*CW +: CW], 0);
    tick();

    // random traffic; an input clears its served bit two cycles after grant
    pend = '0; g_prev = -1; g_prev2 = -1;
    for (int c = 0; c < 400; c++) begin
      if (g_prev2 >= 0) pend[g_prev2] = 1'b0;
      pend = pend | (NP'($urandom) & NP'($urandom));
      head_data = $urandom;
      applyStimulus(pend, ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0));
      g_prev2 = g_prev;
      g_prev  = exp_g;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
